// File: rtl/err_pipe_pkg.sv
// Shared types and constants for the error-resilient pipeline sink.
// Holds FSM state enums, the minimum synchronizer depth and the dual-rail
// encoding of the timing-error evaluation result ({Err1, Err0}).
package err_pipe_pkg;

    localparam int SYNC_MIN = 2;

    // Dual-rail rail pair, bit 1 = Err1 (error true), bit 0 = Err0 (error false).
    localparam logic [1:0] DR_NULL  = 2'b00;
    localparam logic [1:0] DR_FALSE = 2'b01;
    localparam logic [1:0] DR_TRUE  = 2'b10;

    typedef enum logic {
        D_IDLE,
        D_ACK
    } d_state_e;

    typedef enum logic {
        E_IDLE,
        E_HOLD
    } e_state_e;

    typedef enum logic [1:0] {
        R_IDLE,
        R_REQ,
        R_REL
    } r_state_e;

endpackage

// File: rtl/err_sink_stage_sync.sv
// hs_sync: STAGES-deep flop chain bringing an asynchronous handshake wire into clk.
// Latency: STAGES cycles. No backpressure.
// Ports: clk, rst (sync, active-high), d_i async input, q_o synchronized output.
module hs_sync #(
    parameter int STAGES = 2
) (
    input  logic clk,
    input  logic rst,
    input  logic d_i,
    output logic q_o
);

    logic [STAGES-1:0] sync_q;

    always_ff @(posedge clk) begin
        if (rst) begin
            sync_q <= '0;
        end else begin
            sync_q <= {sync_q[STAGES-2:0], d_i};
        end
    end

    assign q_o = sync_q[STAGES-1];

endmodule

// File: rtl/err_sink_stage.sv
// err_sink_stage: clocked right-hand neighbour of the async error-resilient controller.
// Latency: Rack / Err rails rise SYNC_STAGES+1 cycles after Rreq / sample; REreq one cycle after Err1.
// Backpressure: a full output buffer without a pop holds Rack low, stalling the controller.
// Ports:
//   Rreq/Rack, data_main          4-phase data channel from the controller
//   sample/Err1/Err0, data_shadow return-to-zero timing-error evaluation channel
//   REreq/REack                   4-phase error-request channel toward the controller
//   out_data/out_valid/out_ready  one-entry buffer toward synchronous logic
//   err_cnt                       saturating count of Err1 evaluations
module err_sink_stage
    import err_pipe_pkg::*;
#(
    parameter int WIDTH       = 8,
    parameter int SYNC_STAGES = 2,   // legal range 2..4
    parameter int CNT_W       = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             Rreq,
    output logic             Rack,
    input  logic [WIDTH-1:0] data_main,
    input  logic [WIDTH-1:0] data_shadow,
    input  logic             sample,
    output logic             Err1,
    output logic             Err0,
    output logic             REreq,
    input  logic             REack,
    output logic [WIDTH-1:0] out_data,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [CNT_W-1:0] err_cnt
);

    // Never build a chain shorter than the metastability minimum.
    localparam int SYNC_N = (SYNC_STAGES < SYNC_MIN) ? SYNC_MIN : SYNC_STAGES;
    localparam logic [CNT_W-1:0] CNT_MAX = '1;

    logic rreq_s;
    logic sample_s;
    logic reack_s;

    hs_sync #(.STAGES(SYNC_N)) u_sync_rreq (
        .clk (clk),
        .rst (rst),
        .d_i (Rreq),
        .q_o (rreq_s)
    );

    hs_sync #(.STAGES(SYNC_N)) u_sync_sample (
        .clk (clk),
        .rst (rst),
        .d_i (sample),
        .q_o (sample_s)
    );

    hs_sync #(.STAGES(SYNC_N)) u_sync_reack (
        .clk (clk),
        .rst (rst),
        .d_i (REack),
        .q_o (reack_s)
    );

    // ------------------------------------------------------------------
    // Data channel and output buffer
    // ------------------------------------------------------------------
    d_state_e         d_state_q;
    logic             rack_q;
    logic [WIDTH-1:0] out_data_q;
    logic             out_valid_q;
    logic             pop;
    logic             buf_free;

    assign pop      = out_valid_q & out_ready;
    // A pop in the same cycle frees the slot for an immediate capture.
    assign buf_free = ~out_valid_q | pop;

    always_ff @(posedge clk) begin
        if (rst) begin
            d_state_q   <= D_IDLE;
            rack_q      <= 1'b0;
            out_data_q  <= '0;
            out_valid_q <= 1'b0;
        end else begin
            if (pop) begin
                out_valid_q <= 1'b0;
            end
            case (d_state_q)
                D_IDLE: begin
                    if (rreq_s && buf_free) begin
                        out_data_q  <= data_main;
                        out_valid_q <= 1'b1;   // overrides the pop clear above
                        rack_q      <= 1'b1;
                        d_state_q   <= D_ACK;
                    end
                end
                D_ACK: begin
                    if (!rreq_s) begin
                        rack_q    <= 1'b0;
                        d_state_q <= D_IDLE;
                    end
                end
                default: begin
                    rack_q    <= 1'b0;
                    d_state_q <= D_IDLE;
                end
            endcase
        end
    end

    // ------------------------------------------------------------------
    // Timing-error evaluation (dual-rail, return-to-zero)
    // ------------------------------------------------------------------
    e_state_e   e_state_q;
    logic [1:0] rail_q;
    logic       eval_now;
    logic       mismatch;
    logic       err_event;

    // out_data_q here is the pre-capture word when a capture lands in the same cycle.
    assign eval_now  = (e_state_q == E_IDLE) && sample_s;
    assign mismatch  = (data_shadow != out_data_q);
    assign err_event = eval_now && mismatch;

    always_ff @(posedge clk) begin
        if (rst) begin
            e_state_q <= E_IDLE;
            rail_q    <= DR_NULL;
        end else begin
            case (e_state_q)
                E_IDLE: begin
                    if (sample_s) begin
                        rail_q    <= mismatch ? DR_TRUE : DR_FALSE;
                        e_state_q <= E_HOLD;
                    end
                end
                E_HOLD: begin
                    if (!sample_s) begin
                        rail_q    <= DR_NULL;
                        e_state_q <= E_IDLE;
                    end
                end
                default: begin
                    rail_q    <= DR_NULL;
                    e_state_q <= E_IDLE;
                end
            endcase
        end
    end

    // ------------------------------------------------------------------
    // Error-request channel with a 1-deep pending flag
    // ------------------------------------------------------------------
    r_state_e r_state_q;
    logic     rereq_q;
    logic     pend_q;
    logic     issue;

    assign issue = (r_state_q == R_IDLE) && pend_q && !reack_s;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state_q <= R_IDLE;
            rereq_q   <= 1'b0;
            pend_q    <= 1'b0;
        end else begin
            // A fresh error wins over the consume so it is not lost.
            if (err_event) begin
                pend_q <= 1'b1;
            end else if (issue) begin
                pend_q <= 1'b0;
            end
            case (r_state_q)
                R_IDLE: begin
                    if (issue) begin
                        rereq_q   <= 1'b1;
                        r_state_q <= R_REQ;
                    end
                end
                R_REQ: begin
                    if (reack_s) begin
                        rereq_q   <= 1'b0;
                        r_state_q <= R_REL;
                    end
                end
                R_REL: begin
                    if (!reack_s) begin
                        r_state_q <= R_IDLE;
                    end
                end
                default: begin
                    rereq_q   <= 1'b0;
                    r_state_q <= R_IDLE;
                end
            endcase
        end
    end

    // ------------------------------------------------------------------
    // Saturating error counter
    // ------------------------------------------------------------------
    logic [CNT_W-1:0] cnt_q;
    logic [CNT_W-1:0] cnt_d;

    assign cnt_d = (err_event && (cnt_q != CNT_MAX)) ? cnt_q + 1'b1 : cnt_q;

    always_ff @(posedge clk) begin
        if (rst) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign Rack      = rack_q;
    assign Err1      = rail_q[1];
    assign Err0      = rail_q[0];
    assign REreq     = rereq_q;
    assign out_data  = out_data_q;
    assign out_valid = out_valid_q;
    assign err_cnt   = cnt_q;

endmodule

// File: tb/tb_err_sink_stage.sv
// Directed bench for err_sink_stage: a CNT_W=8 instance plus a CNT_W=2 instance
// sharing all inputs so counter saturation is observable on the second one.
module tb_err_sink_stage;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       Rreq = 1'b0;
    logic [7:0] data_main = 8'h00;
    logic [7:0] data_shadow = 8'h00;
    logic       sample = 1'b0;
    logic       out_ready = 1'b0;
    wire        REack;

    logic       Rack, Err1, Err0, REreq, out_valid;
    logic [7:0] out_data, err_cnt;
    logic       s_Rack, s_Err1, s_Err0, s_REreq, s_out_valid;
    logic [7:0] s_out_data;
    logic [1:0] s_err_cnt;

    // REack responder: either a 5-cycle delayed copy of REreq or a manual level.
    logic       auto_ack = 1'b0;
    logic       manual_ack = 1'b0;
    logic [4:0] hist = 5'b0;
    assign REack = auto_ack ? hist[4] : manual_ack;

    always #5 clk = ~clk;

    always @(negedge clk) hist <= {hist[3:0], REreq};

    err_sink_stage #(.WIDTH(8), .SYNC_STAGES(2), .CNT_W(8)) u_dut (
        .clk(clk), .rst(rst), .Rreq(Rreq), .Rack(Rack),
        .data_main(data_main), .data_shadow(data_shadow), .sample(sample),
        .Err1(Err1), .Err0(Err0), .REreq(REreq), .REack(REack),
        .out_data(out_data), .out_valid(out_valid), .out_ready(out_ready),
        .err_cnt(err_cnt)
    );

    err_sink_stage #(.WIDTH(8), .SYNC_STAGES(2), .CNT_W(2)) u_sat (
        .clk(clk), .rst(rst), .Rreq(Rreq), .Rack(s_Rack),
        .data_main(data_main), .data_shadow(data_shadow), .sample(sample),
        .Err1(s_Err1), .Err0(s_Err0), .REreq(s_REreq), .REack(REack),
        .out_data(s_out_data), .out_valid(s_out_valid), .out_ready(out_ready),
        .err_cnt(s_err_cnt)
    );

    int total = 0;
    int bad = 0;
    int rise_cnt = 0;
    logic rereq_prev = 1'b0;
    int exp_cnt = 0;

    typedef struct {
        logic [7:0] dm;
        logic [7:0] ds;
        logic       e1;
        logic       e0;
    } vec_t;

    vec_t vecs[6];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // Every cycle advance samples at the falling edge, tracks REreq rises and
    // checks the dual-rail exclusivity.
    task automatic step(input int n = 1);
        for (int i = 0; i < n; i++) begin
            @(negedge clk);
            if (REreq && !rereq_prev) rise_cnt++;
            rereq_prev = REreq;
            total++;
            if (Err1 && Err0) begin
                bad++;
                $display("FAIL dual_rail: Err1=1 Err0=1 required never both");
            end
        end
    endtask

    function automatic logic sig(input int w);
        case (w)
            0: return Rack;
            1: return Err1;
            2: return Err0;
            3: return REreq;
            4: return REack;
            5: return out_valid;
            6: return Err1 | Err0;
            default: return 1'b0;
        endcase
    endfunction

    task automatic wait_sig(input string name, input int w, input logic v, input int budget);
        int n = 0;
        while (sig(w) !== v && n < budget) begin
            step();
            n++;
        end
        total++;
        if (sig(w) !== v) begin
            bad++;
            $display("FAIL %s: timeout after %0d cycles, got %b expected %b", name, n, sig(w), v);
        end
    endtask

    task automatic pop_buf();
        out_ready = 1'b1;
        step();
        out_ready = 1'b0;
        chk("pop_valid", 32'(out_valid), 0);
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1);
    end

    initial begin
        vecs[0] = '{dm: 8'hA5, ds: 8'hA5, e1: 1'b0, e0: 1'b1};
        vecs[1] = '{dm: 8'hA5, ds: 8'hA4, e1: 1'b1, e0: 1'b0};
        vecs[2] = '{dm: 8'h00, ds: 8'h00, e1: 1'b0, e0: 1'b1};
        vecs[3] = '{dm: 8'hFF, ds: 8'h7F, e1: 1'b1, e0: 1'b0};
        vecs[4] = '{dm: 8'h5A, ds: 8'h5A, e1: 1'b0, e0: 1'b1};
        vecs[5] = '{dm: 8'h3C, ds: 8'hC3, e1: 1'b1, e0: 1'b0};

        // Reset state
        step(3);
        chk("rst_rack", 32'(Rack), 0);
        chk("rst_err1", 32'(Err1), 0);
        chk("rst_err0", 32'(Err0), 0);
        chk("rst_rereq", 32'(REreq), 0);
        chk("rst_valid", 32'(out_valid), 0);
        chk("rst_data", 32'(out_data), 0);
        chk("rst_cnt", 32'(err_cnt), 0);
        chk("rst_sat_cnt", 32'(s_err_cnt), 0);
        rst = 1'b0;

        // Capture latency and 4-phase release
        data_main = 8'hA5;
        Rreq = 1'b1;
        step(2);
        chk("t1_rack_early", 32'(Rack), 0);
        step(1);
        chk("t1_rack", 32'(Rack), 1);
        chk("t1_data", 32'(out_data), 32'hA5);
        chk("t1_valid", 32'(out_valid), 1);
        Rreq = 1'b0;
        step(2);
        chk("t1_rack_hold", 32'(Rack), 1);
        step(1);
        chk("t1_rack_fall", 32'(Rack), 0);

        // Backpressure, then simultaneous pop and capture
        data_main = 8'h3C;
        Rreq = 1'b1;
        step(6);
        chk("t2_rack_stall", 32'(Rack), 0);
        chk("t2_data_kept", 32'(out_data), 32'hA5);
        chk("t2_valid_kept", 32'(out_valid), 1);
        out_ready = 1'b1;
        step(1);
        out_ready = 1'b0;
        chk("t2_rack", 32'(Rack), 1);
        chk("t2_data", 32'(out_data), 32'h3C);
        chk("t2_valid", 32'(out_valid), 1);
        Rreq = 1'b0;
        wait_sig("t2_rack_fall", 0, 1'b0, 10);
        pop_buf();

        // Table: capture, evaluate, and serve the error request
        auto_ack = 1'b1;
        for (int i = 0; i < 6; i++) begin
            data_main = vecs[i].dm;
            Rreq = 1'b1;
            wait_sig("vec_rack", 0, 1'b1, 10);
            chk("vec_data", 32'(out_data), 32'(vecs[i].dm));
            Rreq = 1'b0;
            wait_sig("vec_rack_fall", 0, 1'b0, 10);

            data_shadow = vecs[i].ds;
            sample = 1'b1;
            step(2);
            chk("vec_rail_early", 32'(Err1 | Err0), 0);
            step(1);
            if (vecs[i].e1) exp_cnt++;
            chk("vec_err1", 32'(Err1), 32'(vecs[i].e1));
            chk("vec_err0", 32'(Err0), 32'(vecs[i].e0));
            chk("vec_cnt", 32'(err_cnt), 32'(exp_cnt));
            chk("vec_sat_cnt", 32'(s_err_cnt), 32'((exp_cnt > 3) ? 3 : exp_cnt));
            step(1);
            chk("vec_rereq_next", 32'(REreq), 32'(vecs[i].e1));
            sample = 1'b0;
            wait_sig("vec_rtz", 6, 1'b0, 10);
            chk("vec_rtz_err1", 32'(Err1), 0);
            if (vecs[i].e1) begin
                wait_sig("vec_rereq_fall", 3, 1'b0, 20);
                wait_sig("vec_reack_fall", 4, 1'b0, 20);
                step(4);
                chk("vec_rereq_idle", 32'(REreq), 0);
            end
            pop_buf();
        end
        auto_ack = 1'b0;
        manual_ack = 1'b0;

        // Pending flag depth and counter saturation (fresh counters)
        rst = 1'b1;
        step(2);
        rst = 1'b0;
        step(1);
        chk("t5_cnt_clr", 32'(err_cnt), 0);
        rise_cnt = 0;
        for (int k = 0; k < 3; k++) begin
            data_shadow = 8'h01 + 8'(k);
            sample = 1'b1;
            wait_sig("t5_err1", 1, 1'b1, 10);
            chk("t5_cnt_step", 32'(err_cnt), 32'(k + 1));
            sample = 1'b0;
            wait_sig("t5_rtz", 6, 1'b0, 10);
        end
        chk("t5_cnt3", 32'(err_cnt), 3);
        chk("t5_sat_cnt3", 32'(s_err_cnt), 3);
        chk("t5_one_req", 32'(rise_cnt), 1);
        chk("t5_rereq_high", 32'(REreq), 1);
        manual_ack = 1'b1;
        wait_sig("t5_rel1", 3, 1'b0, 10);
        manual_ack = 1'b0;
        wait_sig("t5_req2", 3, 1'b1, 15);
        chk("t5_two_req", 32'(rise_cnt), 2);
        manual_ack = 1'b1;
        wait_sig("t5_rel2", 3, 1'b0, 10);
        manual_ack = 1'b0;
        step(12);
        chk("t5_dropped", 32'(rise_cnt), 2);
        chk("t5_rereq_low", 32'(REreq), 0);
        for (int k = 0; k < 2; k++) begin
            data_shadow = 8'h10 + 8'(k);
            sample = 1'b1;
            wait_sig("t5_err1_more", 1, 1'b1, 10);
            sample = 1'b0;
            wait_sig("t5_rtz_more", 6, 1'b0, 10);
        end
        chk("t5_cnt5", 32'(err_cnt), 5);
        chk("t5_sat_hold", 32'(s_err_cnt), 3);

        // Reset mid-handshake, then restart with Rreq and sample still high
        data_main = 8'h77;
        Rreq = 1'b1;
        wait_sig("t6_rack", 0, 1'b1, 10);
        chk("t6_data", 32'(out_data), 32'h77);
        data_shadow = 8'h00;
        sample = 1'b1;
        wait_sig("t6_err1", 1, 1'b1, 10);
        chk("t6_pre_rack", 32'(Rack), 1);
        chk("t6_pre_rereq", 32'(REreq), 1);
        rst = 1'b1;
        data_shadow = 8'h77;
        step(1);
        chk("t6_rack", 32'(Rack), 0);
        chk("t6_err1", 32'(Err1), 0);
        chk("t6_err0", 32'(Err0), 0);
        chk("t6_rereq", 32'(REreq), 0);
        chk("t6_valid", 32'(out_valid), 0);
        chk("t6_data0", 32'(out_data), 0);
        chk("t6_cnt", 32'(err_cnt), 0);
        chk("t6_sat_cnt", 32'(s_err_cnt), 0);
        rst = 1'b0;
        step(2);
        chk("t6_rack_early", 32'(Rack), 0);
        chk("t6_err1_early", 32'(Err1), 0);
        step(1);
        chk("t6_recap_rack", 32'(Rack), 1);
        chk("t6_recap_data", 32'(out_data), 32'h77);
        chk("t6_recap_valid", 32'(out_valid), 1);
        // Evaluation in the capture cycle sees the pre-capture word (0).
        chk("t6_same_cycle_err1", 32'(Err1), 1);
        chk("t6_same_cycle_err0", 32'(Err0), 0);
        chk("t6_same_cycle_cnt", 32'(err_cnt), 1);

        Rreq = 1'b0;
        sample = 1'b0;
        step(10);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/err_sink_stage.md
Name: err_sink_stage

Overview:
- Clocked right-hand neighbour for the asynchronous error-resilient pipeline controller.
- Terminates the controller's three outgoing interfaces:
  - data channel: Rreq in, Rack out, 4-phase.
  - timing-error sample channel: sample in, dual-rail Err1/Err0 out, return-to-zero.
  - error-request channel: REreq out, REack in, 4-phase.
- Captured words go to a one-entry output buffer for synchronous logic; detected errors are counted.

Parameters:
- WIDTH, 8, data width of main and shadow inputs and of the output word.
- SYNC_STAGES, 2, flop depth of each input synchronizer (Rreq, sample, REack); legal range 2..4.
- CNT_W, 8, width of the saturating error counter.

Ports:
- clk  in  1  system clock.
- rst  in  1  reset, synchronous, active-high.
- Rreq  in  1  4-phase data request from the controller.
- Rack  out  1  4-phase data acknowledge.
- data_main  in  WIDTH  main-latch data; stable while Rreq=1.
- data_shadow  in  WIDTH  shadow-latch data; stable while sample=1.
- sample  in  1  error-evaluation request from the controller.
- Err1  out  1  dual-rail error true.
- Err0  out  1  dual-rail error false.
- REreq  out  1  4-phase error request toward the controller.
- REack  in  1  error acknowledge from the controller.
- out_data  out  WIDTH  buffered word.
- out_valid  out  1  buffer full.
- out_ready  in  1  consumer pop; a pop occurs when out_valid and out_ready are both 1.
- err_cnt  out  CNT_W  saturating count of Err1 evaluations.

Behaviour:
- Reset (sync, rst=1): every output is 0; all FSMs return to IDLE; synchronizer flops and the pending flag clear; the buffer empties. This applies mid-handshake too. The controller side must be reset concurrently.
- Synchronizers: rreq_s, sample_s, reack_s are the last flop of each SYNC_STAGES chain. Every FSM decision below uses only synchronized signals.
- Data FSM (D_IDLE, D_ACK):
  - D_IDLE: Rack=0. If rreq_s=1 and the buffer is free, capture data_main into out_data, set out_valid=1, set Rack=1, go to D_ACK.
  - The buffer counts as free if out_valid=0, or if a pop happens in the same cycle (simultaneous pop and capture is allowed).
  - If the buffer is full with no pop, stay in D_IDLE with Rack held 0 (backpressure).
  - D_ACK: wait for rreq_s=0, then Rack=0 and go to D_IDLE.
  - Latency: Rack rises SYNC_STAGES+1 cycles after Rreq rises, when the buffer is free.
- Sample FSM (E_IDLE, E_HOLD):
  - E_IDLE: Err1=Err0=0. On rreq... no: on sample_s=1, compare data_shadow with out_data (the last captured word). On mismatch set Err1=1; on match set Err0=1. Then go to E_HOLD.
  - Err1 and Err0 are never both 1.
  - E_HOLD: hold the rail until sample_s=0, then both rails 0 and go to E_IDLE (return-to-zero).
  - A new evaluation needs sample_s to be seen at 0 for at least 1 cycle first.
- Error-request FSM (R_IDLE, R_REQ, R_REL):
  - Every Err1 assertion sets the 1-deep pending flag.
  - R_IDLE: if pending=1 and reack_s=0, set REreq=1, clear pending, go to R_REQ.
  - R_REQ: on reack_s=1, set REreq=0 and go to R_REL.
  - R_REL: on reack_s=0, go to R_IDLE.
  - An error arriving while pending is already 1 is dropped from the request channel but still counted.
- err_cnt: increments by 1 on each Err1 assertion cycle and saturates at 2^CNT_W-1 with no wrap. It is not cleared by any other event.
- Simultaneous events: the three FSMs are independent. A capture in the same cycle as a sample evaluation compares against the pre-capture out_data.

Decomposition:
- Shared package err_pipe_pkg holds:
  - state enums for data, sample and error-request FSMs;
  - constant SYNC_MIN=2;
  - the dual-rail encoding constants: null 00, false 01 (Err0), true 10 (Err1).
- One sub-module, hs_sync: a parameterized SYNC_STAGES flop chain with sync reset, instantiated three times.

Test Plan:
1. Reset, then Rreq=1 with data_main=8'hA5 and out_ready=0 → Rack=1 at cycle SYNC_STAGES+1 (3); out_data=A5, out_valid=1. Drop Rreq → Rack=0 3 cycles later.
2. Buffer full (out_ready=0) and a second Rreq=1 → Rack stays 0. Pulse out_ready=1 → capture completes and Rack rises the following cycle.
3. out_data=A5; sample=1 with data_shadow=A5 → Err0=1, Err1=0, no REreq. Drop sample → both rails 0.
4. sample=1 with data_shadow=A4 → Err1=1 and err_cnt=1. REreq=1 one cycle later. Tie REack to REreq with 5-cycle delay → REreq falls after reack_s=1, and the FSM returns to R_IDLE.
5. Three mismatches while REack is held 0 → err_cnt=3, exactly one further REreq issued after release, the third request dropped. With CNT_W=2, a fourth and fifth error → err_cnt holds 3.
6. Assert rst=1 while Rack=1, Err1=1 and REreq=1 → all outputs 0 on the next edge. Release rst with Rreq still 1 → a fresh capture occurs after the synchronizer latency.
